// File: rtl/pus_tx_data_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : pus_tx_data_mux_if
// Description : Lane data/handshake bundle for the PUSCH transmit data mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface pus_tx_data_mux_if;
    logic [7:0][63:0] pus_tx_data;
    logic [7:0]       pus_tx_vld;
    logic [7:0]       cpri_tx_rdy;
    logic [7:0][63:0] cpri_tx_data;
    logic [7:0]       cpri_tx_vld;
    logic [7:0][63:0] tv_data;
    logic [7:0]       tv_vld;

    modport master (
        output pus_tx_data, pus_tx_vld, cpri_tx_rdy,
        input  cpri_tx_data, cpri_tx_vld, tv_data, tv_vld
    );

    modport slave (
        input  pus_tx_data, pus_tx_vld, cpri_tx_rdy,
        output cpri_tx_data, cpri_tx_vld, tv_data, tv_vld
    );
endinterface
`default_nettype wire

// File: rtl/pus_tx_data_mux.sv
`default_nettype none
// ============================================================================
// Module      : pus_tx_data_mux
// Description : Eight-lane PUSCH transmit mux: per-lane prefill FIFO drained
//               to CPRI under ready handshake, plus test-vector capture path.
// Revision    : 1.0 - initial release
// ============================================================================
module pus_tx_data_mux #(
    parameter int FIFO_DEPTH = 16,
    parameter int START_LVL  = 4
) (
    input  wire logic        i_clk,
    input  wire logic        i_rst_n,
    input  wire logic        i_data_sel,
    input  wire logic        i_ovf_clr,
    output logic [7:0]       o_ovf,
    pus_tx_data_mux_if.slave bus
);
    localparam int              AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     c_DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]     c_START = (AW+1)'(START_LVL);
    localparam logic [0:0]      S_IDLE  = 1'b0;
    localparam logic [0:0]      S_RUN   = 1'b1;

    logic [7:0][63:0] r_tv_data;
    logic [7:0]       r_tv_vld;

    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
        logic [63:0]   r_mem [FIFO_DEPTH];
        logic [AW-1:0] r_wptr;
        logic [AW-1:0] r_rptr;
        logic [AW:0]   r_cnt;
        logic [0:0]    r_state;
        logic [63:0]   r_dout;
        logic          r_vout;
        logic          r_ovf;
        logic          w_full;
        logic          w_wr;
        logic          w_ovf;
        logic          w_rd;

        // Full test uses the registered level: a same-cycle pop never frees a slot.
        assign w_full = (r_cnt == c_DEPTH);
        assign w_wr   = bus.pus_tx_vld[gi] & ~i_data_sel & ~w_full;
        assign w_ovf  = bus.pus_tx_vld[gi] & ~i_data_sel &  w_full;
        assign w_rd   = ((r_state == S_RUN) || (r_cnt >= c_START)) &&
                        (r_cnt != '0) && bus.cpri_tx_rdy[gi] && !i_data_sel;

        always_ff @(posedge i_clk) begin
            if (w_wr) begin
                r_mem[r_wptr] <= bus.pus_tx_data[gi];
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_cnt   <= '0;
                r_state <= S_IDLE;
                r_dout  <= '0;
                r_vout  <= 1'b0;
                r_ovf   <= 1'b0;
            end else begin
                if (i_data_sel) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end else begin
                    if (w_wr) begin
                        r_wptr <= r_wptr + 1'b1;
                    end
                    if (w_rd) begin
                        r_rptr <= r_rptr + 1'b1;
                    end
                    if (w_wr && !w_rd) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (!w_wr && w_rd) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    case (r_state)
                        S_IDLE:  if (r_cnt >= c_START) r_state <= S_RUN;
                        S_RUN:   if ((r_cnt == '0) && !w_wr) r_state <= S_IDLE;
                        default: r_state <= S_IDLE;
                    endcase
                end

                // Capture mode overrides the hold-on-not-ready rule.
                if (i_data_sel) begin
                    r_vout <= 1'b0;
                end else if (bus.cpri_tx_rdy[gi]) begin
                    r_vout <= w_rd;
                    if (w_rd) begin
                        r_dout <= r_mem[r_rptr];
                    end
                end

                if (w_ovf) begin
                    r_ovf <= 1'b1;
                end else if (i_ovf_clr) begin
                    r_ovf <= 1'b0;
                end
            end
        end

        assign bus.cpri_tx_data[gi] = r_dout;
        assign bus.cpri_tx_vld[gi]  = r_vout;
        assign o_ovf[gi]            = r_ovf;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tv_data <= '0;
            r_tv_vld  <= '0;
        end else if (i_data_sel) begin
            r_tv_data <= bus.pus_tx_data;
            r_tv_vld  <= bus.pus_tx_vld;
        end else begin
            r_tv_vld  <= '0;
        end
    end

    assign bus.tv_data = r_tv_data;
    assign bus.tv_vld  = r_tv_vld;
endmodule
`default_nettype wire

// File: doc/pus_tx_data_mux.md
# pus_tx_data_mux

Transmit-side counterpart of the PUSCH receive data mux. It accepts eight 64-bit lanes of processed PUSCH data in the core clock domain and buffers each lane in its own synchronous FIFO. Each lane is drained toward its CPRI transmit lane under a per-lane ready handshake, after a prefill threshold is reached. A test-vector select bypasses the FIFOs and routes the input lanes to a capture port for bench/ILA comparison.

## Interface
- FIFO_DEPTH, 16: words per lane FIFO; power of two, 4–256.
- START_LVL, 4: FIFO level that must be reached before a lane starts draining; 1 ≤ START_LVL ≤ FIFO_DEPTH.

- i_clk  in  1  core/data clock; the only clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_data_sel  in  1  1 = test-vector capture mode, 0 = CPRI transmit mode.
- i_pus_tx_data  in  [7:0][63:0]  per-lane data.
- i_pus_tx_vld  in  [7:0]  per-lane write strobe.
- i_cpri_tx_rdy  in  [7:0]  per-lane consumer ready.
- i_ovf_clr  in  1  clears all sticky overflow flags.
- o_cpri_tx_data  out  [7:0][63:0]  registered lane data.
- o_cpri_tx_vld  out  [7:0]  registered lane valid.
- o_tv_data  out  [7:0][63:0]  capture data.
- o_tv_vld  out  [7:0]  capture valid.
- o_ovf  out  [7:0]  sticky per-lane overflow.

## Operation
- **Lanes.** The eight lanes are identical and independent. Each lane has a FIFO, a registered level count `cnt` (0..FIFO_DEPTH), a 2-state FSM (IDLE, RUN) and an output register.
- **Write.** When i_pus_tx_vld[i]=1, i_data_sel=0 and cnt<FIFO_DEPTH, the word is written.
  - If cnt==FIFO_DEPTH, the word is dropped and o_ovf[i] is set.
  - The full check uses the registered cnt, so a pop in the same cycle does not make room.
- **Pop.** The pop condition is (state==RUN or cnt≥START_LVL) and cnt≠0 and i_cpri_tx_rdy[i]=1 and i_data_sel=0.
- **Level.** cnt updates +1 on write only, −1 on pop only, and is unchanged on simultaneous write and pop.
- **FSM.**
  - IDLE→RUN when cnt≥START_LVL.
  - RUN→IDLE when cnt==0 at an edge with no write. The lane must then prefill again.
  - Both states go to IDLE on i_data_sel=1.
- **Output register.**
  - If i_cpri_tx_rdy[i]=0, o_cpri_tx_data[i] and o_cpri_tx_vld[i] hold.
  - If i_cpri_tx_rdy[i]=1, the register loads the popped FIFO head with vld=1. If no pop occurs, vld=0 and data holds.
  - A word is consumed at every edge where vld and rdy are both 1.
- **Capture mode (i_data_sel=1).**
  - All FIFOs are flushed (cnt=0, contents discarded) and every FSM is forced to IDLE.
  - o_cpri_tx_vld=0 at the next edge.
  - o_tv_data/o_tv_vld register i_pus_tx_data/i_pus_tx_vld every cycle.
  - When i_data_sel=0, o_tv_vld=0 and o_tv_data holds.
- **Overflow flags.** o_ovf is cleared by i_ovf_clr. If a clear and a new overflow occur in the same cycle, set wins.

## Timing
- **Reset.** Reset is asynchronous. Every output resets to 0, all cnt=0 and all FSMs are in IDLE. Deassertion is synchronous to i_clk and is handled outside this block.
- **Latency with START_LVL=1.** A word sampled at edge N is popped at edge N+1 and is on o_cpri_tx_data after N+1.
- **General latency.** The lane starts draining on the edge after the edge where cnt reaches START_LVL.
- **Throughput.** Sustained throughput is one word per cycle per lane with continuous rdy.
- **Capture path.** One edge of latency.
- **Mode switch.**
  - i_data_sel 0→1 flushes at the sampling edge; words in flight in the FIFOs are lost by design.
  - i_data_sel 1→0: writes are accepted from the first edge with sel=0.
- **Reset mid-operation.** All state clears immediately; no partial word is emitted.

## Test plan
- **Prefill and drain.**
  - Stimulus: START_LVL=4, lane0 writes 0x1..0x4 at edges N..N+3, rdy=1.
  - Response: o_cpri_tx_vld[0]=1 from after N+4, data 0x1,0x2,0x3,0x4 on consecutive cycles, then vld=0 and FSM back in IDLE.
- **Backpressure.**
  - Stimulus: 8 words streamed on lane3, rdy[3] low for 3 cycles mid-drain.
  - Response: output holds its word while rdy is low; sequence complete and in order; no duplicates; o_ovf[3]=0.
- **Overflow.**
  - Stimulus: FIFO_DEPTH=16, rdy[5]=0, 17 writes 0x10..0x20.
  - Response: o_ovf[5]=1 after the 17th write. With rdy=1, exactly 0x10..0x1F are drained. i_ovf_clr then returns o_ovf[5] to 0.
- **Capture mode.**
  - Stimulus: lanes hold 6 words, then i_data_sel=1 with input 0xAA on all lanes, vld=0xFF.
  - Response: o_cpri_tx_vld=0 next cycle; o_tv_data=0xAA on all lanes and o_tv_vld=0xFF one cycle later. After sel=0, nothing is drained until START_LVL new words arrive.
- **Reset mid-burst.**
  - Stimulus: i_rst_n low while lane7 is draining.
  - Response: all outputs 0 immediately. After release, the first output is the first word written post-reset.
- **Lane independence.**
  - Stimulus: lanes 0–7 receive different word counts with random rdy.
  - Response: each lane's output sequence exactly matches its own input order.
